usbfs_debug_uart_tx: RTL and testbench

USBFS_DEBUG_UART_TX -- requirements
Module: usbfs_debug_uart_tx

---
 rtl/usbfs_debug_uart_tx.sv | 185 ++++++++++++++++++
 tb/tb_usbfs_debug_uart_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/usbfs_debug_uart_tx.sv
// Debug byte stream to UART 8N1: a byte FIFO feeds a bit-timed serializer.
// Define USBFS_DEBUG_DROP_CNT_EN to count bytes discarded on overflow.
module usbfs_debug_uart_tx #(
  parameter int CLK_DIV = 434,
  parameter int FIFO_AW = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        debug_en,
  input  logic [7:0]  debug_data,
  output logic        uart_tx,
  output logic        fifo_full,
  output logic [15:0] drop_cnt
);

  localparam int          DEPTH    = 1 << FIFO_AW;
  localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] wr_ptr_d, rd_ptr_d;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [7:0]       rd_data;

  // A full FIFO refuses the byte even if the serializer pops on the same edge.
  assign push       = debug_en && !fifo_full;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign rd_data    = mem[rd_ptr[FIFO_AW-1:0]];
  assign wr_ptr_d   = push ? wr_ptr + (FIFO_AW+1)'(1) : wr_ptr;
  assign rd_ptr_d   = pop  ? rd_ptr + (FIFO_AW+1)'(1) : rd_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_full <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      wr_ptr    <= wr_ptr_d;
      rd_ptr    <= rd_ptr_d;
      fifo_full <= (wr_ptr_d[FIFO_AW] != rd_ptr_d[FIFO_AW]) &&
                   (wr_ptr_d[FIFO_AW-1:0] == rd_ptr_d[FIFO_AW-1:0]);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers define
  // which entries are valid, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= debug_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------------
  state_t      state, state_d;
  logic [15:0] bit_cnt, bit_cnt_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  shreg, shreg_d;
  logic        tx_d;
  logic        bit_done;

  assign bit_done = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      uart_tx <= tx_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d   = state;
    bit_cnt_d = bit_cnt;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    tx_d      = uart_tx;
    pop       = 1'b0;

    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_d   = rd_data;
          tx_d      = 1'b0;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end

      START: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          tx_d      = shreg[0];
          shreg_d   = {1'b0, shreg[7:1]};
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt + 16'd1;
        end
      end

      DATA: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          if (bit_idx == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            tx_d      = shreg[0];
            shreg_d   = {1'b0, shreg[7:1]};
          end
        end else begin
          bit_cnt_d = bit_cnt + 16'd1;
        end
      end

      STOP: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          // Chain straight into the next start bit so frames abut.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = rd_data;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt + 16'd1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Overflow drop counter
  // ---------------------------------------------------------------------------
`ifdef USBFS_DEBUG_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_q;

  assign drop = debug_en && fifo_full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_usbfs_debug_uart_tx.sv
// Directed bench for usbfs_debug_uart_tx (CLK_DIV=4, FIFO_AW=2) with a UART monitor.
module tb_usbfs_debug_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int FIFO_AW = 2;
`ifdef USBFS_DEBUG_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        debug_en = 1'b0;
  logic [7:0]  debug_data = 8'h00;
  logic        uart_tx;
  logic        fifo_full;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  usbfs_debug_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .debug_en   (debug_en),
    .debug_data (debug_data),
    .uart_tx    (uart_tx),
    .fifo_full  (fifo_full),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART receiver: samples mid-bit on falling clock edges, records bytes and start cycles.
  logic [7:0] rx_q[$];
  int         start_q[$];
  bit         mon_busy = 1'b0;
  int         mon_cnt  = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      mon_busy = 1'b0;
      mon_cnt  = 0;
    end else if (!mon_busy) begin
      if (uart_tx == 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) check("mon_start_bit", uart_tx, 1'b0);
      if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2)
        mon_byte = {uart_tx, mon_byte[7:1]};
      if (mon_cnt == 38) check("mon_stop_bit", uart_tx, 1'b1);
      if (mon_cnt == 39) begin
        rx_q.push_back(mon_byte);
        mon_busy = 1'b0;
      end
    end
  end

  // Drive a one-cycle write strobe; call and return at posedge+1.
  task automatic write_byte(input logic [7:0] b);
    debug_en   = 1'b1;
    debug_data = b;
    @(posedge clk); #1;
    debug_en   = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // frame[k] = k-th bit on the line, start first
  } vec_t;

  vec_t vecs[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] b6_bytes[6];
    int         n0;
    bit         saw_low;

    vecs[0] = '{8'h41, 10'b1010000010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'hA5, 10'b1101001010};

    // Reset state
    wait_cycles(3);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_fifo_full", fifo_full, 1'b0);
    check("rst_drop_cnt", drop_cnt, 16'h0);
    @(negedge clk); rstn = 1'b1;
    wait_cycles(3);
    check("post_rst_idle", uart_tx, 1'b1);

    // Single-byte frames, bit by bit
    for (int i = 0; i < 4; i++) begin
      rx_q.delete(); start_q.delete();
      write_byte(vecs[i].data);
      check($sformatf("vec%0d_lat_n", i), uart_tx, 1'b1);
      wait_cycles(1);
      check($sformatf("vec%0d_lat_n1", i), uart_tx, 1'b0);
      wait_cycles(2);
      for (int k = 0; k < 10; k++) begin
        check($sformatf("vec%0d_bit%0d", i, k), uart_tx, vecs[i].frame[k]);
        wait_cycles(CLK_DIV);
      end
      check($sformatf("vec%0d_idle", i), uart_tx, 1'b1);
      check($sformatf("vec%0d_rx_n", i), rx_q.size(), 1);
      if (rx_q.size() > 0) check($sformatf("vec%0d_rx", i), rx_q[0], vecs[i].data);
      wait_cycles(5);
    end

    // Three back-to-back frames
    rx_q.delete(); start_q.delete();
    debug_en = 1'b1; debug_data = 8'h0A;
    @(posedge clk); #1; n0 = cyc;
    debug_data = 8'h73;
    @(posedge clk); #1;
    debug_data = 8'h75;
    @(posedge clk); #1;
    debug_en = 1'b0;
    wait_cycles(125);
    check("b2b_rx_n", rx_q.size(), 3);
    check("b2b_starts_n", start_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("b2b_rx0", rx_q[0], 8'h0A);
      check("b2b_rx1", rx_q[1], 8'h73);
      check("b2b_rx2", rx_q[2], 8'h75);
    end
    if (start_q.size() == 3) begin
      check("b2b_first_start", start_q[0], n0 + 1);
      check("b2b_gap01", start_q[1] - start_q[0], 10 * CLK_DIV);
      check("b2b_gap12", start_q[2] - start_q[1], 10 * CLK_DIV);
    end

    // Overflow, then a write colliding with the STOP pop
    rx_q.delete(); start_q.delete();
    b6_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    for (int i = 0; i < 6; i++) begin
      debug_en = 1'b1; debug_data = b6_bytes[i];
      @(posedge clk); #1;
      if (i == 0) n0 = cyc;
      if (i == 3) check("ovf_not_full_n3", fifo_full, 1'b0);
      if (i == 4) check("ovf_full_n4", fifo_full, 1'b1);
    end
    debug_en = 1'b0;
    check("ovf_full_n5", fifo_full, 1'b1);
    check("ovf_drop1", drop_cnt, DROP_EN ? 16'd1 : 16'd0);
    wait_cycles(35);
    check("ovf_full_n40", fifo_full, 1'b1);
    write_byte(8'h37);
    check("pop_drop_not_full", fifo_full, 1'b0);
    check("pop_drop_cnt2", drop_cnt, DROP_EN ? 16'd2 : 16'd0);
    write_byte(8'h38);
    check("pop_drop_refill_full", fifo_full, 1'b1);
    wait_cycles(220);
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h38};
    check("ovf_rx_n", rx_q.size(), 6);
    if (rx_q.size() == 6)
      for (int i = 0; i < 6; i++) check($sformatf("ovf_rx%0d", i), rx_q[i], exp_q[i]);
    check("ovf_drained", fifo_full, 1'b0);

    // Asynchronous reset during data bit 3
    rx_q.delete(); start_q.delete();
    write_byte(8'hF0);
    write_byte(8'h5A);
    wait_cycles(17);
    check("arst_pre_bit3", uart_tx, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("arst_uart_tx", uart_tx, 1'b1);
    check("arst_fifo_full", fifo_full, 1'b0);
    check("arst_drop_cnt", drop_cnt, 16'h0);
    @(negedge clk); rstn = 1'b1;
    wait_cycles(1);
    saw_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (uart_tx !== 1'b1) saw_low = 1'b1;
      wait_cycles(1);
    end
    check("arst_no_frame", saw_low, 1'b0);
    check("arst_rx_none", rx_q.size(), 0);
    write_byte(8'hC3);
    wait_cycles(45);
    check("arst_new_rx_n", rx_q.size(), 1);
    if (rx_q.size() == 1) check("arst_new_rx", rx_q[0], 8'hC3);

    // Paced stream wrapping the pointers many times
    rx_q.delete(); start_q.delete(); exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(8'(i * 37 + 11));
      write_byte(8'(i * 37 + 11));
      wait_cycles(39);
    end
    wait_cycles(50);
    check("wrap_rx_n", rx_q.size(), 40);
    if (rx_q.size() == 40)
      for (int i = 0; i < 40; i++) check($sformatf("wrap_rx%0d", i), rx_q[i], exp_q[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
